// File: rtl/bus_defs_pkg.sv
// Shared bus definitions: data width, access-size and FSM state encodings,
// and the alignment check used when a request is accepted.
package bus_defs;

   localparam int BUS_WIDTH = 32;

   localparam logic [1:0] SIZE_B = 2'b00;
   localparam logic [1:0] SIZE_H = 2'b01;
   localparam logic [1:0] SIZE_W = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_WRITE = 2'b01,
      ST_READ  = 2'b10,
      ST_RESP  = 2'b11
   } state_t;

   // Size 11 is illegal; halves need an even address, words a 4-byte aligned one.
   function automatic logic req_misaligned(input logic [1:0] size, input logic [1:0] off);
      case (size)
         SIZE_B:  return 1'b0;
         SIZE_H:  return off[0];
         SIZE_W:  return (off != 2'b00);
         default: return 1'b1;
      endcase
   endfunction

endpackage

// File: rtl/lsu_bus_master_align.sv
// Byte-lane steering: byte enables and replicated store data for the bus,
// and lane extraction plus sign/zero extension for load data.
module lsu_align
   import bus_defs::*;
(
   input  logic [1:0]           i_off,
   input  logic [1:0]           i_size,
   input  logic                 i_unsigned,
   input  logic [BUS_WIDTH-1:0] i_wdata,
   input  logic [BUS_WIDTH-1:0] i_rdata,
   output logic [3:0]           o_be,
   output logic [BUS_WIDTH-1:0] o_wdata,
   output logic [BUS_WIDTH-1:0] o_ldata
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   function automatic logic [BUS_WIDTH-1:0] ext_byte(input logic [7:0] b, input logic uns);
      logic signed [7:0] sb;
      sb = b;
      return uns ? {24'd0, b} : BUS_WIDTH'(sb);
   endfunction

   function automatic logic [BUS_WIDTH-1:0] ext_half(input logic [15:0] h, input logic uns);
      logic signed [15:0] sh;
      sh = h;
      return uns ? {16'd0, h} : BUS_WIDTH'(sh);
   endfunction

   always_comb begin
      o_be    = 4'b0000;
      o_wdata = '0;
      o_ldata = '0;
      w_byte  = i_rdata[{i_off, 3'b000} +: 8];
      w_half  = i_off[1] ? i_rdata[31:16] : i_rdata[15:0];
      case (i_size)
         SIZE_B: begin
            o_be    = 4'b0001 << i_off;
            o_wdata = {4{i_wdata[7:0]}};
            o_ldata = ext_byte(w_byte, i_unsigned);
         end
         SIZE_H: begin
            o_be    = i_off[1] ? 4'b1100 : 4'b0011;
            o_wdata = {2{i_wdata[15:0]}};
            o_ldata = ext_half(w_half, i_unsigned);
         end
         SIZE_W: begin
            o_be    = 4'b1111;
            o_wdata = i_wdata;
            o_ldata = i_rdata;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/lsu_bus_master.sv
// Load/store bus initiator: one request at a time, word-aligned bus cycle,
// single-cycle response pulse back to the core's memory stage.
module lsu_bus_master
   import bus_defs::*;
#(
   parameter int WIDTH        = 32,
   parameter int READ_LATENCY = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic             req_we,
   input  logic [1:0]       req_size,
   input  logic             req_unsigned,
   input  logic [WIDTH-1:0] req_addr,
   input  logic [WIDTH-1:0] req_wdata,
   output logic             resp_valid,
   output logic [WIDTH-1:0] resp_rdata,
   output logic             resp_err,
   output logic [WIDTH-1:0] addr,
   output logic             we,
   output logic [3:0]       be,
   output logic [WIDTH-1:0] wdata,
   input  logic [WIDTH-1:0] rdata
);

   localparam logic [2:0] LAST_CNT = 3'(READ_LATENCY);

   state_t           r_state;
   state_t           w_next;
   logic [WIDTH-1:0] r_addr;
   logic [WIDTH-1:0] r_wdata;
   logic [WIDTH-1:0] r_resp_rdata;
   logic [1:0]       r_size;
   logic             r_uns;
   logic             r_err;
   logic [2:0]       r_cnt;
   logic             w_bad;
   logic             w_last;
   logic [3:0]       w_be;
   logic [WIDTH-1:0] w_wdata;
   logic [WIDTH-1:0] w_ldata;

   assign w_bad      = req_misaligned(req_size, req_addr[1:0]);
   assign w_last     = (r_cnt == LAST_CNT);
   assign resp_rdata = r_resp_rdata;
   assign resp_err   = resp_valid & r_err;

   lsu_align u_align (
      .i_off      (r_addr[1:0]),
      .i_size     (r_size),
      .i_unsigned (r_uns),
      .i_wdata    (r_wdata),
      .i_rdata    (rdata),
      .o_be       (w_be),
      .o_wdata    (w_wdata),
      .o_ldata    (w_ldata)
   );

   // Bus and response outputs decode from state, so reset clears them at once.
   always_comb begin
      w_next     = r_state;
      req_ready  = 1'b0;
      resp_valid = 1'b0;
      addr       = '0;
      we         = 1'b0;
      be         = 4'b0000;
      wdata      = '0;
      case (r_state)
         ST_IDLE: begin
            req_ready = 1'b1;
            if (req_valid) w_next = w_bad ? ST_RESP : (req_we ? ST_WRITE : ST_READ);
         end
         ST_WRITE: begin
            addr   = {r_addr[WIDTH-1:2], 2'b00};
            we     = 1'b1;
            be     = w_be;
            wdata  = w_wdata;
            w_next = ST_RESP;
         end
         ST_READ: begin
            addr = {r_addr[WIDTH-1:2], 2'b00};
            be   = w_be;
            if (w_last) w_next = ST_RESP;
         end
         ST_RESP: begin
            resp_valid = 1'b1;
            w_next     = ST_IDLE;
         end
         default: w_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= ST_IDLE;
         r_cnt        <= 3'd0;
         r_err        <= 1'b0;
         r_resp_rdata <= '0;
      end else begin
         r_state <= w_next;
         case (r_state)
            ST_IDLE: begin
               r_cnt <= 3'd0;
               if (req_valid) begin
                  r_err <= w_bad;
                  if (w_bad) r_resp_rdata <= '0;
               end
            end
            ST_WRITE: r_resp_rdata <= '0;
            // rdata is only looked at on the edge closing the last READ cycle.
            ST_READ: begin
               if (w_last) r_resp_rdata <= w_ldata;
               else        r_cnt        <= r_cnt + 3'd1;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (r_state == ST_IDLE && req_valid) begin
         r_addr  <= req_addr;
         r_wdata <= req_wdata;
         r_size  <= req_size;
         r_uns   <= req_unsigned;
      end
   end

endmodule

// File: doc/lsu_bus_master.md
# lsu_bus_master

- Initiator side of the peripheral bus. Accepts one load/store request at a time from the core pipeline and drives the word-aligned bus toward `bus_interconnect`:
  - Outputs: `addr`, `we`, `be`, `wdata`.
  - Input: `rdata`, which the interconnect muxes from RAM or GPIO.
- Handles byte-lane placement and read-data extraction with sign or zero extension.
- Returns a single-cycle response to the core.
- Sits between the core's memory stage and the interconnect.

## Interface

Parameters:
- `WIDTH`, 32, data/address width. Only 32 is supported; it fixes 4 byte lanes.
- `READ_LATENCY`, 1, number of cycles from the bus address to valid `rdata`. Legal range 1–7.

Ports:
- One clock; reset is asynchronous and active-low. Ports are `clk` and `rst_n`.
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in 1: core presents a request.
- `req_ready` out 1: the block accepts the request on this edge when `req_valid` is also high.
- `req_we` in 1: 1 = store, 0 = load.
- `req_size` in 2: 00 = byte, 01 = half, 10 = word, 11 = illegal.
- `req_unsigned` in 1: zero-extend loads. Ignored for stores and word loads.
- `req_addr` in WIDTH: byte address.
- `req_wdata` in WIDTH: store data, right-aligned.
- `resp_valid` out 1: one-cycle completion pulse.
- `resp_rdata` out WIDTH: extended load data. 0 for stores and errors.
- `resp_err` out 1: misaligned or illegal request. Qualified by `resp_valid`.
- `addr` out WIDTH: bus address, `{req_addr[31:2],2'b00}`.
- `we` out 1: bus write enable.
- `be` out 4: byte enables.
- `wdata` out WIDTH: lane-placed store data.
- `rdata` in WIDTH: bus read data.

## Operation

States:
- **IDLE**
  - `req_ready`=1.
  - Bus outputs are all 0.
  - On `req_valid`: latch the request and check alignment.
    - Error condition: `req_size`=11, or half with `addr[0]`=1, or word with `addr[1:0]`≠0.
    - On error, go to RESP with `err` set and no bus activity.
    - Otherwise go to WRITE if `req_we`, else READ.
- **WRITE**
  - Lasts exactly 1 cycle, with `we`=1 and `addr`, `be`, `wdata` driven.
  - Next state: RESP.
- **READ**
  - Lasts READ_LATENCY+1 cycles, with `we`=0, `be` driven, and `addr` held constant.
  - A 3-bit cycle counter tracks the duration.
  - `rdata` is captured, extracted and extended on the edge that ends the last READ cycle. Next state: RESP.
- **RESP**
  - `resp_valid`=1 for exactly 1 cycle, `req_ready`=0.
  - Next state: IDLE.

Lane rules (off = `req_addr[1:0]`):
- Byte: `be` = 1<<off, `wdata` = {4{wdata[7:0]}}, load = `rdata[8*off+:8]`.
- Half: `be` = 4'b0011 when `addr[1]`=0, 4'b1100 when `addr[1]`=1. `wdata` = {2{wdata[15:0]}}. Load = `rdata[16*addr[1]+:16]`.
- Word: `be` = 4'b1111, full passthrough.

Extension:
- Byte and half loads are sign-extended unless `req_unsigned`=1.
- `resp_rdata` is registered and holds its value until the next RESP.

## Timing

- The request is accepted on edge E. Cycle 1 is the cycle after E.
- Store:
  - `we` high in cycle 1.
  - `resp_valid` in cycle 2.
- Load:
  - Bus active in cycles 1 to READ_LATENCY+1.
  - `resp_valid` in cycle READ_LATENCY+2 (cycle 3 at default).
- Error: `resp_valid` with `resp_err`=1 in cycle 1.
- Throughput:
  - The next request is accepted no earlier than the edge ending RESP.
  - There is no overlap; `req_ready` is low outside IDLE.
- Reset values:
  - State is IDLE.
  - `addr`, `we`, `be`, `wdata`, `resp_valid`, `resp_rdata` and `resp_err` are all 0.
  - `req_ready` decodes to 1, but requests are ignored while `rst_n` is low.
- Reset mid-operation:
  - Outputs clear immediately (asynchronously).
  - No `resp_valid` is issued for the aborted request.
  - A store aborted in WRITE deasserts `we` immediately.
- `req_*` inputs are don't-care outside IDLE. Latched copies drive all outputs.
- `rdata` is sampled only on the capture edge. X on `rdata` at any other time must not propagate.

## Structure

- Shared include/package `bus_defs`:
  - `WIDTH` define.
  - Size encodings `SIZE_B`, `SIZE_H`, `SIZE_W`.
  - State encodings `ST_IDLE`, `ST_WRITE`, `ST_READ`, `ST_RESP`.
- Sub-module `lsu_align`: purely combinational.
  - Inputs: offset, size, unsigned, `req_wdata`, `rdata`.
  - Outputs: `be`, placed `wdata`, extended load data.
- The top level holds the FSM, the latency counter and the output registers.

## Test plan

- **Word store:** `req_addr`=0x10, size=10, `req_wdata`=0xDEADBEEF.
  - Cycle 1: `addr`=0x10, `we`=1, `be`=1111, `wdata`=0xDEADBEEF.
  - Cycle 2: `resp_valid`=1, `resp_err`=0.
- **Signed byte load:** `req_addr`=0x13, `rdata`=0x80FF0102.
  - Cycle 3: `resp_rdata`=0xFFFFFF80.
  - Same load with `req_unsigned`=1 gives 0x00000080.
- **Half store:** `req_addr`=0x06, `req_wdata`=0x0000ABCD.
  - `be`=1100, `wdata`=0xABCDABCD.
  - Signed half load of the same lane with `rdata`=0xABCD0000 gives 0xFFFFABCD.
- **Misaligned and illegal requests:**
  - Word at 0x02 gives `resp_valid`=`resp_err`=1 in cycle 1, with `we`=0 and `be`=0 throughout.
  - `req_size`=11 gives the same response.
- **Latency:** READ_LATENCY=3.
  - `addr` is stable for 4 cycles.
  - `rdata` is X except in the final READ cycle.
  - `resp_valid` arrives in cycle 5 with the correct data.
  - `req_ready`=0 from cycle 1 through RESP.
- **Reset mid-read:** drop `rst_n` in READ cycle 1.
  - All outputs are 0 immediately; no `resp_valid` follows.
  - After release, a new store completes normally.
